// File: rtl/link_arbiter_pkg.sv
// Shared definitions for the req/ack link arbiter: handshake state encoding
// and counter widths used by the arbiter and its helpers.
package link_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        ACK_HI = 2'd2,
        REQ_LO = 2'd3
    } link_state_t;

    localparam int XFER_CNT_W = 16;
    localparam int WDOG_W     = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request strictly
// after ptr (wrapping), by rotating, priority-encoding and un-rotating.
module rr_pick #(
    parameter int N_MASTERS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic                 valid,
    output logic [PTR_W-1:0]     idx
);

    logic [2*N_MASTERS-1:0] dbl;
    logic [N_MASTERS-1:0]   rot;
    logic                   found;
    int                     start;
    int                     pos;

    always_comb begin
        valid = |req;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        start = int'(ptr) + 1;
        if (start >= N_MASTERS) start = start - N_MASTERS;
        dbl = {req, req};
        rot = dbl[start +: N_MASTERS];
        for (int j = 0; j < N_MASTERS; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = start + j;
                if (pos >= N_MASTERS) pos = pos - N_MASTERS;
                idx   = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/link_arbiter.sv
// Shares one 4-phase req/ack slave link among N master links: round-robin
// grant per complete handshake, watchdog on a silent slave, transfer count.
module link_arbiter
    import link_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*DATA_W-1:0]   m_data,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic                          s_req,
    output logic [DATA_W-1:0]             s_data,
    input  logic                          s_ack,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy,
    output logic                          err,
    output logic [XFER_CNT_W-1:0]         xfer_cnt
);

    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    link_state_t         state;
    logic [PW-1:0]       sel;
    logic [PW-1:0]       ptr;
    logic [WDOG_W-1:0]   wdog;
    logic                acked;
    logic                pick_vld;
    logic [PW-1:0]       pick_idx;
    logic                wdog_hit;

    function automatic logic [N_MASTERS-1:0] onehot(input logic [PW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    rr_pick #(
        .N_MASTERS (N_MASTERS),
        .PTR_W     (PW)
    ) u_pick (
        .req   (m_req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // wdog holds the number of completed cycles already spent in the state,
    // so the TIMEOUT-th cycle is the one that trips the error.
    assign wdog_hit = (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            ptr      <= PW'(N_MASTERS - 1);
            err      <= 1'b0;
            xfer_cnt <= '0;
            wdog     <= '0;
            acked    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wdog  <= '0;
                    acked <= 1'b0;
                    if (pick_vld) begin
                        sel   <= pick_idx;
                        grant <= onehot(pick_idx);
                        state <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (s_ack) begin
                        state <= ACK_HI;
                        acked <= 1'b1;
                        wdog  <= '0;
                    end else if (!m_req[sel]) begin
                        state <= REQ_LO;
                        wdog  <= '0;
                    end else if (wdog_hit) begin
                        err   <= 1'b1;
                        state <= REQ_LO;
                        wdog  <= '0;
                    end else begin
                        wdog  <= wdog + 1'b1;
                    end
                end
                ACK_HI: begin
                    wdog <= '0;
                    if (!m_req[sel]) state <= REQ_LO;
                end
                REQ_LO: begin
                    if (!s_ack) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= sel;
                        wdog  <= '0;
                        if (acked) xfer_cnt <= xfer_cnt + 1'b1;
                    end else if (wdog_hit) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= sel;
                        wdog  <= '0;
                    end else begin
                        wdog  <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // s_req tracks the granted master's req through ACK_HI so its fall is
    // passed to the slave in the same cycle the master drops it.
    assign busy  = (state != IDLE);
    assign s_req = m_req[sel] & ((state == REQ_HI) | (state == ACK_HI));
    assign m_ack = (s_ack && (state != IDLE)) ? grant : '0;

    always_comb begin
        s_data = '0;
        if (|grant) s_data = m_data[int'(sel)*DATA_W +: DATA_W];
    end

endmodule

// File: tb/tb_link_arbiter.sv
// Directed self-checking bench for link_arbiter (4 masters, 8-bit data,
// watchdog TIMEOUT=10).
module tb_link_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N*DW-1:0] m_data;
    logic [N-1:0]    m_ack;
    logic            s_req;
    logic [DW-1:0]   s_data;
    logic            s_ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            err;
    logic [15:0]     xfer_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] dval [N] = '{8'h11, 8'h5A, 8'hA5, 8'h3C};

    link_arbiter #(
        .N_MASTERS (N),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_data   (m_data),
        .m_ack    (m_ack),
        .s_req    (s_req),
        .s_data   (s_data),
        .s_ack    (s_ack),
        .grant    (grant),
        .busy     (busy),
        .err      (err),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        m_req = '0;
        s_ack = 1'b0;
        #2;
        rst = 1'b1;
        tick(1);
    endtask

    task automatic finish_xfer(input logic [N-1:0] g);
        s_ack = 1'b1;
        tick(1);
        m_req = m_req & ~g;
        tick(1);
        s_ack = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        m_req  = '0;
        s_ack  = 1'b0;
        m_data = {dval[3], dval[2], dval[1], dval[0]};
        #3;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b want %b", grant, 4'b0000); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_sreq: got %b want 0", s_req); end
        checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL rst_mack: got %b want 0000", m_ack); end
        checks++; if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL rst_cnt: got %h want 0000", xfer_cnt); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_busy_err: got %b%b want 00", busy, err); end
        checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL rst_sdata: got %h want 00", s_data); end
        rst   = 1'b1;
        m_req = 4'b0001;
        tick(1);
        checks++; if (grant !== 4'b0001 || s_req !== 1'b1) begin errors++; $display("FAIL pre_rst_grant: got %b/%b want 0001/1", grant, s_req); end
        checks++; if (s_data !== 8'h11) begin errors++; $display("FAIL pre_rst_sdata: got %h want 11", s_data); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== 4'b0001) begin errors++; $display("FAIL pre_rst_mack: got %b want 0001", m_ack); end
        rst = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || s_req !== 1'b0) begin errors++; $display("FAIL midrst_grant: got %b/%b want 0000/0", grant, s_req); end
        checks++; if (m_ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL midrst_mack: got %b/%b want 0000/0", m_ack, busy); end
        checks++; if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL midrst_cnt: got %h want 0000", xfer_cnt); end
        rst   = 1'b1;
        m_req = '0;
        s_ack = 1'b0;
        tick(1);
    endtask

    task automatic test_single();
        do_reset();
        m_req = 4'b0100;
        tick(1);
        checks++; if (grant !== 4'b0100 || s_req !== 1'b1) begin errors++; $display("FAIL single_grant: got %b/%b want 0100/1", grant, s_req); end
        checks++; if (s_data !== 8'hA5) begin errors++; $display("FAIL single_sdata: got %h want a5", s_data); end
        checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL single_mack_pre: got %b want 0000", m_ack); end
        tick(2);
        checks++; if (grant !== 4'b0100 || busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL single_wait: got %b/%b/%b want 0100/1/0", grant, busy, err); end
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== 4'b0100) begin errors++; $display("FAIL single_mack_hi: got %b want 0100", m_ack); end
        tick(1);
        checks++; if (s_req !== 1'b1 || m_ack !== 4'b0100) begin errors++; $display("FAIL single_ackhi: got %b/%b want 1/0100", s_req, m_ack); end
        m_req = 4'b0000;
        #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL single_sreq_fall: got %b want 0", s_req); end
        tick(1);
        checks++; if (grant !== 4'b0100 || xfer_cnt !== 16'd0) begin errors++; $display("FAIL single_reqlo: got %b/%h want 0100/0000", grant, xfer_cnt); end
        s_ack = 1'b0;
        #1;
        checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL single_mack_lo: got %b want 0000", m_ack); end
        tick(1);
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b/%b want 0000/0", grant, busy); end
        checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %h want 0001", xfer_cnt); end
        checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL single_sdata_idle: got %h want 00", s_data); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] g;
        do_reset();
        m_req = 4'b1111;
        tick(1);
        for (int k = 0; k < 8; k++) begin
            g = 4'b0001 << (k % 4);
            checks++; if (grant !== g) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", k, grant, g); end
            checks++; if (s_data !== dval[k % 4]) begin errors++; $display("FAIL fair_sdata%0d: got %h want %h", k, s_data, dval[k % 4]); end
            finish_xfer(g);
            m_req = 4'b1111;
            tick(1);
        end
        checks++; if (xfer_cnt !== 16'd8) begin errors++; $display("FAIL fair_cnt: got %h want 0008", xfer_cnt); end
    endtask

    task automatic test_late_joiner();
        do_reset();
        m_req = 4'b0010;
        tick(1);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL late_first: got %b want 0010", grant); end
        m_req = 4'b0011;
        s_ack = 1'b1;
        tick(1);
        checks++; if (grant !== 4'b0010 || m_ack !== 4'b0010) begin errors++; $display("FAIL late_ackhi: got %b/%b want 0010/0010", grant, m_ack); end
        m_req = 4'b0001;
        tick(1);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL late_reqlo: got %b want 0010", grant); end
        s_ack = 1'b0;
        tick(1);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL late_idle: got %b want 0000", grant); end
        tick(1);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL late_next0: got %b want 0001", grant); end

        do_reset();
        m_req = 4'b0010;
        tick(1);
        m_req = 4'b0111;
        s_ack = 1'b1;
        tick(1);
        m_req = 4'b0101;
        tick(1);
        s_ack = 1'b0;
        tick(1);
        checks++; if (xfer_cnt !== 16'd1 || grant !== 4'b0000) begin errors++; $display("FAIL late_cnt: got %h/%b want 0001/0000", xfer_cnt, grant); end
        tick(1);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL late_next2: got %b want 0100", grant); end
    endtask

    task automatic test_timeout();
        do_reset();
        m_req = 4'b1000;
        tick(1);
        tick(9);
        checks++; if (err !== 1'b0 || grant !== 4'b1000 || s_req !== 1'b1) begin errors++; $display("FAIL to_before: got %b/%b/%b want 0/1000/1", err, grant, s_req); end
        m_req = 4'b1001;
        tick(1);
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL to_err: got %b/%b want 1/1", err, busy); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL to_sreq: got %b want 0", s_req); end
        tick(1);
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL to_drop: got %b/%b want 0000/0", grant, busy); end
        checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL to_cnt: got %h want 0000", xfer_cnt); end
        tick(1);
        checks++; if (grant !== 4'b0001 || err !== 1'b1) begin errors++; $display("FAIL to_next: got %b/%b want 0001/1", grant, err); end
    endtask

    task automatic test_withdraw();
        do_reset();
        s_ack = 1'b1;
        #1;
        checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL idle_ack_mack: got %b want 0000", m_ack); end
        tick(1);
        checks++; if (busy !== 1'b0 || m_ack !== 4'b0000) begin errors++; $display("FAIL idle_ack_busy: got %b/%b want 0/0000", busy, m_ack); end
        s_ack = 1'b0;
        m_req = 4'b1000;
        tick(1);
        checks++; if (grant !== 4'b1000 || s_req !== 1'b1) begin errors++; $display("FAIL wd_grant: got %b/%b want 1000/1", grant, s_req); end
        m_req = 4'b0000;
        #1;
        checks++; if (s_req !== 1'b0 || m_ack !== 4'b0000) begin errors++; $display("FAIL wd_sreq: got %b/%b want 0/0000", s_req, m_ack); end
        tick(1);
        checks++; if (busy !== 1'b1 || m_ack !== 4'b0000 || s_req !== 1'b0) begin errors++; $display("FAIL wd_reqlo: got %b/%b/%b want 1/0000/0", busy, m_ack, s_req); end
        tick(1);
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got %b/%b want 0000/0", grant, busy); end
        checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL wd_cnt: got %h want 0000", xfer_cnt); end

        force dut.xfer_cnt = 16'hFFFF;
        #1;
        release dut.xfer_cnt;
        #1;
        checks++; if (xfer_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h want ffff", xfer_cnt); end
        m_req = 4'b0001;
        tick(1);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b want 0001", grant); end
        finish_xfer(4'b0001);
        checks++; if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h want 0000", xfer_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_late_joiner();
        test_timeout();
        test_withdraw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
